// File: rtl/fp_arith_pkg.sv
// Shared arithmetic helpers for the FP datapath.
// fs_bit is the reference 1-bit full-subtractor for behavioural models.
package fp_arith_pkg;

  // Returns {borrow_out, difference} for one bit position.
  function automatic logic [1:0] fs_bit(input logic a, input logic b, input logic bi);
    logic d;
    logic bo;
    d  = a ^ b ^ bi;
    bo = (~a & b) | (~(a ^ b) & bi);
    return {bo, d};
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: D = A - B - BI, with borrow-out BO.
// Purely combinational leaf used for each bit of the ripple chain.
module full_subtractor_cell (
  input  logic A,
  input  logic B,
  input  logic BI,
  output logic D,
  output logic BO
);

  logic w_axb;

  assign w_axb = A ^ B;
  assign D     = w_axb ^ BI;
  // Borrow when B exceeds A outright, or when they tie and a borrow arrives.
  assign BO    = (~A & B) | (~w_axb & BI);

endmodule

// File: rtl/full_subtractor.sv
// Ripple-borrow subtractor {BO, D} = A - B - BI over WIDTH bits, with an
// optional one-cycle output register stage qualified by in_valid/out_valid.
module full_subtractor
  import fp_arith_pkg::*;
#(
  parameter int unsigned WIDTH      = 1,
  parameter bit          REGISTERED = 1'b0
) (
  output logic [WIDTH-1:0] D,
  output logic             BO,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_diff;
  logic [WIDTH:0]   w_borrow;

  assign w_borrow[0] = BI;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor_cell u_cell (
      .A  (A[i]),
      .B  (B[i]),
      .BI (w_borrow[i]),
      .D  (w_diff[i]),
      .BO (w_borrow[i+1])
    );
  end

  if (REGISTERED) begin : g_reg
    logic [WIDTH-1:0] r_d;
    logic             r_bo;
    logic             r_valid;

    // Data holds when in_valid is low; only the valid flag tracks every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_d     <= '0;
        r_bo    <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= in_valid;
        if (in_valid) begin
          r_d  <= w_diff;
          r_bo <= w_borrow[WIDTH];
        end
      end
    end

    assign D         = r_d;
    assign BO        = r_bo;
    assign out_valid = r_valid;
  end else begin : g_comb
    logic w_unused;

    // Control inputs are intentionally ignored in the combinational build.
    assign w_unused  = ^{clk, rst_n, in_valid};
    assign D         = w_diff;
    assign BO        = w_borrow[WIDTH];
    assign out_valid = 1'b1;
  end

endmodule

// File: tb/tb_full_subtractor.sv
// Directed and randomised checks of full_subtractor in combinational and
// registered builds at widths 1, 8 and 16.
module tb_full_subtractor;

  logic clk;
  logic rst_n;
  logic in_valid;

  int checks;
  int errors;

  // WIDTH=1 combinational
  logic a1, b1, bi1, d1, bo1, ov1;
  // WIDTH=8 combinational and registered share inputs
  logic [7:0] a8, b8, d8c, d8r;
  logic       bi8, bo8c, bo8r, ov8c, ov8r;
  // WIDTH=16 combinational and registered share inputs
  logic [15:0] a16, b16, d16c, d16r;
  logic        bi16, bo16c, bo16r, ov16c, ov16r;

  full_subtractor #(.WIDTH(1), .REGISTERED(1'b0)) u_w1 (
    .D(d1), .BO(bo1), .A(a1), .B(b1), .BI(bi1),
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .out_valid(ov1)
  );

  full_subtractor #(.WIDTH(8), .REGISTERED(1'b0)) u_w8c (
    .D(d8c), .BO(bo8c), .A(a8), .B(b8), .BI(bi8),
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .out_valid(ov8c)
  );

  full_subtractor #(.WIDTH(8), .REGISTERED(1'b1)) u_w8r (
    .D(d8r), .BO(bo8r), .A(a8), .B(b8), .BI(bi8),
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .out_valid(ov8r)
  );

  full_subtractor #(.WIDTH(16), .REGISTERED(1'b0)) u_w16c (
    .D(d16c), .BO(bo16c), .A(a16), .B(b16), .BI(bi16),
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .out_valid(ov16c)
  );

  full_subtractor #(.WIDTH(16), .REGISTERED(1'b1)) u_w16r (
    .D(d16r), .BO(bo16r), .A(a16), .B(b16), .BI(bi16),
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .out_valid(ov16r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({d8r, bo8r, ov8r} !== 10'b0) begin
      errors++;
      $display("FAIL reset_w8r got d=%h bo=%b ov=%b want d=00 bo=0 ov=0", d8r, bo8r, ov8r);
    end
    checks++;
    if ({d16r, bo16r, ov16r} !== 18'b0) begin
      errors++;
      $display("FAIL reset_w16r got d=%h bo=%b ov=%b want 0 0 0", d16r, bo16r, ov16r);
    end
    checks++;
    if ({ov1, ov8c, ov16c} !== 3'b111) begin
      errors++;
      $display("FAIL comb_out_valid got %b want 111", {ov1, ov8c, ov16c});
    end
  endtask

  task automatic test_truth_table();
    logic [7:0] tt_d;
    logic [7:0] tt_bo;
    logic [2:0] idx;
    tt_d  = 8'b1001_0110;
    tt_bo = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      idx = i[2:0];
      {a1, b1, bi1} = idx;
      #1;
      checks++;
      if ({d1, bo1} !== {tt_d[i], tt_bo[i]}) begin
        errors++;
        $display("FAIL truth_table abi=%b got d=%b bo=%b want d=%b bo=%b",
                 idx, d1, bo1, tt_d[i], tt_bo[i]);
      end
    end
  endtask

  task automatic test_w8_comb();
    logic [7:0]  va [5];
    logic [7:0]  vb [5];
    logic        vbi[5];
    logic [7:0]  vd [5];
    logic        vbo[5];
    va = '{8'h10, 8'h00, 8'h05, 8'h5A, 8'hFF};
    vb = '{8'h01, 8'h00, 8'h07, 8'h5A, 8'h00};
    vbi = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vd = '{8'h0F, 8'hFF, 8'hFE, 8'h00, 8'hFF};
    vbo = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      a8 = va[i];
      b8 = vb[i];
      bi8 = vbi[i];
      #1;
      checks++;
      if ({d8c, bo8c} !== {vd[i], vbo[i]}) begin
        errors++;
        $display("FAIL w8_comb a=%h b=%h bi=%b got d=%h bo=%b want d=%h bo=%b",
                 va[i], vb[i], vbi[i], d8c, bo8c, vd[i], vbo[i]);
      end
    end
  endtask

  task automatic test_w8_reg();
    @(negedge clk);
    rst_n = 1'b1;
    a8 = 8'h80; b8 = 8'h7F; bi8 = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({d8r, bo8r, ov8r} !== {8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL w8_reg_load got d=%h bo=%b ov=%b want d=00 bo=0 ov=1", d8r, bo8r, ov8r);
    end
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; bi8 = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({d8r, bo8r, ov8r} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL w8_reg_hold got d=%h bo=%b ov=%b want d=00 bo=0 ov=0", d8r, bo8r, ov8r);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h07; bi8 = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({d8r, bo8r, ov8r} !== {8'hFE, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL w8_reg_preload got d=%h bo=%b ov=%b want d=fe bo=1 ov=1", d8r, bo8r, ov8r);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({d8r, bo8r, ov8r} !== 10'b0) begin
      errors++;
      $display("FAIL async_reset got d=%h bo=%b ov=%b want 0 0 0", d8r, bo8r, ov8r);
    end
    // A rising edge while reset is held must not capture.
    @(posedge clk);
    #1;
    checks++;
    if ({d8r, bo8r, ov8r} !== 10'b0) begin
      errors++;
      $display("FAIL reset_held_edge got d=%h bo=%b ov=%b want 0 0 0", d8r, bo8r, ov8r);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a8 = 8'h03; b8 = 8'h01; bi8 = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({d8r, bo8r, ov8r} !== {8'h02, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL post_reset_load got d=%h bo=%b ov=%b want d=02 bo=0 ov=1", d8r, bo8r, ov8r);
    end
  endtask

  task automatic test_random16();
    logic [16:0] exp_c;
    logic [16:0] exp_r;
    logic        exp_v;
    exp_r = '0;
    exp_v = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      bi16 = 1'($urandom_range(0, 1));
      in_valid = (i == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      exp_c = {1'b0, a16} - {1'b0, b16} - {16'b0, bi16};
      #1;
      checks++;
      if ({bo16c, d16c} !== exp_c) begin
        errors++;
        $display("FAIL rand16_comb a=%h b=%h bi=%b got %h want %h",
                 a16, b16, bi16, {bo16c, d16c}, exp_c);
      end
      if (in_valid) exp_r = exp_c;
      exp_v = in_valid;
      @(posedge clk);
      #1;
      checks++;
      if ({bo16r, d16r, ov16r} !== {exp_r, exp_v}) begin
        errors++;
        $display("FAIL rand16_reg iter=%0d got bo_d=%h ov=%b want bo_d=%h ov=%b",
                 i, {bo16r, d16r}, ov16r, exp_r, exp_v);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a1 = 1'b0; b1 = 1'b0; bi1 = 1'b0;
    a8 = '0; b8 = '0; bi8 = 1'b0;
    a16 = '0; b16 = '0; bi16 = 1'b0;
    test_reset();
    test_truth_table();
    test_w8_comb();
    test_w8_reg();
    test_async_reset();
    test_random16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_subtractor.md
Name: full_subtractor

Overview:
- Parameterised ripple-borrow subtractor for the FP datapath (exponent and mantissa difference).
- Computes D = A - B - BI over WIDTH bits and produces a borrow-out.
- The default WIDTH=1 is the classic 1-bit full subtractor.
- Output stage is selectable: combinational, or registered with a valid flag.

Parameters:
- WIDTH, 1, operand/difference width in bits (>=1).
- REGISTERED, 0, 0 = D/BO combinational from inputs; 1 = D/BO/out_valid registered, 1-cycle latency.

Ports:
- clk  input  1  system clock; used only when REGISTERED=1.
- rst_n  input  1  asynchronous active-low reset.
- D  output  WIDTH  difference A - B - BI, modulo 2^WIDTH.
- BO  output  1  borrow-out; 1 when A < B + BI (unsigned).
- A  input  WIDTH  minuend, unsigned.
- B  input  WIDTH  subtrahend, unsigned.
- BI  input  1  borrow-in into the LSB.
- in_valid  input  1  qualifies A/B/BI; used only when REGISTERED=1.
- out_valid  output  1  D/BO valid. Tied 1 when REGISTERED=0.
- Positional order of the first five data ports is fixed: D, BO, A, B, BI. clk, rst_n, in_valid and out_valid are connected by name.

Behaviour:
- Per bit i, with b0 = BI:
  - d_i = A_i ^ B_i ^ b_i
  - b_{i+1} = (~A_i & B_i) | (~(A_i ^ B_i) & b_i)
- BO = b_WIDTH.
- Equivalent arithmetic: {BO, D} = {1'b0, A} - {1'b0, B} - BI, computed in WIDTH+1 bits; BO is bit WIDTH of that result.
- REGISTERED=0:
  - Purely combinational; outputs settle within the same delta/time step as input change.
  - No state; clk and rst_n are ignored.
  - out_valid = 1.
- REGISTERED=1:
  - On rising clk with in_valid=1: D and BO load the combinational result; out_valid <= 1.
  - On rising clk with in_valid=0: D and BO hold; out_valid <= 0.
  - Latency exactly 1 cycle; throughput 1 per cycle; no backpressure.
- Reset (REGISTERED=1), rst_n low: asynchronously D = 0, BO = 0, out_valid = 0, independent of clk.
  - Reset mid-operation discards the in-flight result.
  - First capture occurs on the first rising clk after rst_n deasserts.
- Boundaries:
  - A = B with BI = 0: D = 0, BO = 0.
  - A = 0 with B = 0 and BI = 1: D = all ones, BO = 1 (wrap-around).
  - A = all ones, B = 0, BI = 0: D = all ones, BO = 0.
- No X propagation is masked; X on an input yields X only on the affected bits and the borrow chain above them.

Decomposition:
- Package fp_arith_pkg holds no new typedefs.
  - May export function fs_bit(a, b, bi) returning {bo, d} for reuse by behavioural models.
- One leaf sub-module, full_subtractor_cell: 1-bit D/BO from A/B/BI, pure combinational.
  - Instantiated WIDTH times via generate, borrow chained LSB to MSB.
- Top adds the optional output register stage and out_valid.

Test Plan:
- WIDTH=1, REGISTERED=0, exhaustive truth table: A,B,BI -> D,BO:
  - 000 -> 0,0
  - 001 -> 1,1
  - 010 -> 1,1
  - 011 -> 0,1
  - 100 -> 1,0
  - 101 -> 0,0
  - 110 -> 0,0
  - 111 -> 1,1
- WIDTH=8, REGISTERED=0:
  - A=0x10, B=0x01, BI=0 -> D=0x0F, BO=0
  - A=0x00, B=0x00, BI=1 -> D=0xFF, BO=1
  - A=0x05, B=0x07, BI=0 -> D=0xFE, BO=1
- WIDTH=8, REGISTERED=1: A=0x80, B=0x7F, BI=1, in_valid=1 at edge k -> after edge k: D=0x00, BO=0, out_valid=1; in_valid=0 at edge k+1 -> D/BO hold, out_valid=0.
- Async reset: drive rst_n=0 between clock edges with out_valid=1 -> D=0, BO=0, out_valid=0 immediately; release, apply A=3, B=1, BI=0 -> next edge D=2, BO=0.
- Randomised WIDTH=16, 1000 vectors: D and BO match the WIDTH+1-bit reference subtraction every cycle (REGISTERED=1 compares against inputs delayed 1 cycle).
